rn_w_router: RTL and testbench
==============================

RN_W_ROUTER -- requirements
Module: rn_w_router

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, W-beat buffer entries, power of two, minimum 2.
REQ-002 Parameter DATA_WIDTH, default 128, WDATA width; WSTRB is DATA_WIDTH/8.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 WVALID  input  1  upstream W beat valid.
REQ-006 WREADY  output  1  beat accepted when WVALID & WREADY.
REQ-007 WID  input  11  write ID of beat.
REQ-008 WDATA  input  DATA_WIDTH  beat data.
REQ-009 WSTRB  input  DATA_WIDTH/8  byte strobes.
REQ-010 WLAST  input  1  last beat of burst.
REQ-011 W_TgtID  input  2  target ID from the RN write tracker, valid in the same cycle as the beat.
REQ-012 TGT_WVALID  output  4  one-hot valid; bit n selects target n.
REQ-013 TGT_WREADY  input  4  per-target ready.
REQ-014 TGT_WID / TGT_WDATA / TGT_WSTRB / TGT_WLAST  output  11 / DATA_WIDTH / DATA_WIDTH/8 / 1  shared payload of the FIFO head.
REQ-015 burst_done  output  1  one-cycle pulse when a WLAST beat leaves toward its target.
REQ-016 err_tgt_mismatch  output  1  sticky flag: WID or target changed mid-burst.
REQ-017 beat_cnt  output  16  wrapping count of beats forwarded.

Function
REQ-018 WREADY SHALL be ~full, derived from the registered occupancy only; there is no combinational path from TGT_WREADY.
REQ-019 An accepted beat SHALL be pushed as {tgt, WID, WDATA, WSTRB, WLAST}; tgt is the locked target when the FSM is in BURST, otherwise W_TgtID.
REQ-020 Input FSM states: IDLE, BURST.
  - IDLE → BURST on an accepted beat with WLAST=0; latch tgt and WID.
  - BURST → IDLE on an accepted beat with WLAST=1.
  - An accepted beat in IDLE with WLAST=1 leaves the FSM in IDLE.
REQ-021 In BURST, an accepted beat whose WID or W_TgtID differs from the latched values SHALL set err_tgt_mismatch the next cycle. The beat is still routed to the latched target.
REQ-022 When the FIFO is not empty, TGT_WVALID SHALL equal 1<<head.tgt; when it is empty, TGT_WVALID SHALL be 0. The payload outputs SHALL be driven from the head entry.
REQ-023 The head SHALL pop when TGT_WREADY[head.tgt] & ~empty; ready bits of non-selected targets are ignored.
REQ-024 Minimum latency SHALL be 1 cycle, from the accept edge to TGT_WVALID high; there is no bypass path.
REQ-025 Push and pop SHALL occur in the same cycle when the FIFO is non-empty and not full; occupancy is then unchanged.
REQ-026 Payload SHALL stay stable while TGT_WVALID is high and the selected TGT_WREADY is low.
REQ-027 Head-of-line blocking SHALL hold: no reordering across targets, and beats leave in accept order.
REQ-028 On every pop, beat_cnt SHALL increment modulo 2^16.
REQ-029 burst_done SHALL assert in the cycle of a pop whose TGT_WLAST=1.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty across wrap-around.

Reset
REQ-031 While rst=0, the block SHALL be in this state: FSM IDLE, FIFO empty, WREADY=0, TGT_WVALID=0, burst_done=0, err_tgt_mismatch=0, beat_cnt=0.
REQ-032 After rst deasserts, WREADY SHALL rise on the first clk edge.
REQ-033 FIFO storage SHALL not be reset.
REQ-034 Reset mid-burst SHALL discard all buffered beats and the burst lock.

Structure
REQ-035 Package rn_pkg SHALL hold the constants for ID width 11, target ID width 2 and target count 4, the w_beat_t struct, and the FSM state enum.
REQ-036 The block SHALL instantiate one sub-module, rn_w_fifo: a parameterised synchronous FIFO with push/pop/full/empty and an async active-low reset.

Verification
REQ-037 Scenario: a 4-beat burst with WID=0x12, W_TgtID=2, all TGT_WREADY=1 → TGT_WVALID=4'b0100 for 4 consecutive cycles starting 1 cycle after the first accept; burst_done on beat 4; beat_cnt=4.
REQ-038 Scenario: TGT_WREADY=0 with 5 beats offered at FIFO_DEPTH=4 → 4 beats accepted, WREADY=0 after the 4th; payload held stable; release → 4 pops in order.
REQ-039 Scenario: W_TgtID switches 1→3 on beat 2 of a 3-beat burst → err_tgt_mismatch=1; all 3 beats are output on target 1 (TGT_WVALID=4'b0010).
REQ-040 Scenario: back-to-back single-beat bursts to targets 0,1,2,3 with TGT_WREADY[1]=0 for 5 cycles → target-2 and target-3 beats wait behind target 1; output order is 0,1,2,3.
REQ-041 Scenario: rst pulsed low with 3 beats buffered mid-burst → TGT_WVALID=0 immediately; FSM IDLE; beat_cnt=0; a new burst then routes to its own W_TgtID.
REQ-042 Scenario: 70000 single-beat transfers → beat_cnt = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/rn_pkg.sv
// Package shared by the RN write-data router and its beat FIFO.
// It holds the ID and target widths, the target count, the routing view of a
// buffered W beat, the input FSM state encoding and a one-hot helper.
// The data and strobe fields are not in w_beat_t because their width is a
// module parameter. They travel next to the struct inside the FIFO word.
package rn_pkg;

    localparam int ID_W    = 11;
    localparam int TGT_W   = 2;
    localparam int NUM_TGT = 4;

    // These are the routing fields of a buffered beat: the target, the write ID and the last flag.
    typedef struct packed {
        logic [TGT_W-1:0] tgt;
        logic [ID_W-1:0]  wid;
        logic             last;
    } w_beat_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } w_state_e;

    function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [TGT_W-1:0] tgt);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        oh[tgt] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rn_w_fifo.sv
// This is a parameterised synchronous FIFO that buffers W beats.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset that empties the FIFO (storage keeps its contents)
//   push      write push_data when not full
//   push_data word to store
//   pop       discard the head when not empty
//   pop_data  head word (valid while ~empty)
//   full      all DEPTH entries are occupied
//   empty     no entries are occupied
module rn_w_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Each pointer has one more bit than the address. The extra MSB tells a full FIFO from an empty one when the address bits are equal.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage has no reset. Only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rn_w_router.sv
// This is the RN write-data router. It buffers upstream W beats and steers each
// beat to one of NUM_TGT targets. Beats leave in the order they were accepted.
// A burst is locked to the target and ID of its first beat.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   WVALID/WREADY     upstream W handshake (WREADY depends only on registered state)
//   WID/WDATA/WSTRB/WLAST  upstream beat payload
//   W_TgtID           target of the beat, from the write tracker
//   TGT_WVALID        one-hot valid toward the target of the FIFO head
//   TGT_WREADY        per-target ready (only the selected bit is used)
//   TGT_W*            shared payload of the FIFO head
//   burst_done        pulses when a WLAST beat is handed to its target
//   err_tgt_mismatch  sticky flag, set when the ID or target changes mid-burst
//   beat_cnt          wrapping count of forwarded beats
module rn_w_router
    import rn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [10:0]             WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic [1:0]              W_TgtID,
    output logic [3:0]              TGT_WVALID,
    input  logic [3:0]              TGT_WREADY,
    output logic [10:0]             TGT_WID,
    output logic [DATA_WIDTH-1:0]   TGT_WDATA,
    output logic [DATA_WIDTH/8-1:0] TGT_WSTRB,
    output logic                    TGT_WLAST,
    output logic                    burst_done,
    output logic                    err_tgt_mismatch,
    output logic [15:0]             beat_cnt
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = TGT_W + ID_W + DATA_WIDTH + STRB_W + 1;

    w_state_e         state;
    logic [TGT_W-1:0] lock_tgt;
    logic [ID_W-1:0]  lock_wid;
    logic             ready_en;
    logic             accept;
    logic [TGT_W-1:0] push_tgt;
    logic [BEAT_W-1:0] fifo_wr;
    logic [BEAT_W-1:0] fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    w_beat_t          head;

    // ready_en keeps WREADY low during reset. It releases WREADY on the first clock edge after reset ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    assign WREADY   = ready_en & ~fifo_full;
    assign accept   = WVALID & WREADY;
    assign push_tgt = (state == ST_BURST) ? lock_tgt : W_TgtID;
    assign fifo_wr  = {push_tgt, WID, WDATA, WSTRB, WLAST};

    rn_w_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (fifo_wr),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head.tgt, head.wid, TGT_WDATA, TGT_WSTRB, head.last} = fifo_rd;
    assign TGT_WID    = head.wid;
    assign TGT_WLAST  = head.last;
    assign TGT_WVALID = fifo_empty ? '0 : tgt_onehot(head.tgt);

    // Only the ready bit of the head's target is used. This keeps strict
    // accept order even when another target is ready and this one is not.
    assign pop        = ~fifo_empty & TGT_WREADY[head.tgt];
    assign burst_done = pop & head.last;

    // The first non-last beat locks the target and ID. Beats that follow in
    // the same burst go to the locked target even if the tracker points to
    // another one. Such a disagreement is recorded in the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            lock_tgt         <= '0;
            lock_wid         <= '0;
            err_tgt_mismatch <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!WLAST) begin
                        state    <= ST_BURST;
                        lock_tgt <= W_TgtID;
                        lock_wid <= WID;
                    end
                end
                ST_BURST: begin
                    if ((WID != lock_wid) || (W_TgtID != lock_tgt))
                        err_tgt_mismatch <= 1'b1;
                    if (WLAST)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     beat_cnt <= '0;
        else if (pop) beat_cnt <= beat_cnt + 16'd1;
    end

endmodule

// File: tb/tb_rn_w_router.sv
// This is the self-checking bench for rn_w_router.
// The driver keeps a small model of the burst lock. Each accepted beat is pushed
// into a scoreboard queue with the target it is expected to reach. The monitor
// pops the queue whenever the DUT hands a beat to its selected target, and it
// compares the routing and the payload.
module tb_rn_w_router;

    localparam int DW = 128;
    localparam int SW = DW / 8;

    typedef struct {
        logic [1:0]    tgt;
        logic [10:0]   wid;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          WVALID;
    logic          WREADY;
    logic [10:0]   WID;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST;
    logic [1:0]    W_TgtID;
    logic [3:0]    TGT_WVALID;
    logic [3:0]    TGT_WREADY;
    logic [10:0]   TGT_WID;
    logic [DW-1:0] TGT_WDATA;
    logic [SW-1:0] TGT_WSTRB;
    logic          TGT_WLAST;
    logic          burst_done;
    logic          err_tgt_mismatch;
    logic [15:0]   beat_cnt;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;
    bit          sb_en    = 1'b1;
    bit          m_burst  = 1'b0;
    logic [1:0]  m_tgt    = '0;
    logic [10:0] m_wid    = '0;

    rn_w_router #(.FIFO_DEPTH(4), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .WVALID           (WVALID),
        .WREADY           (WREADY),
        .WID              (WID),
        .WDATA            (WDATA),
        .WSTRB            (WSTRB),
        .WLAST            (WLAST),
        .W_TgtID          (W_TgtID),
        .TGT_WVALID       (TGT_WVALID),
        .TGT_WREADY       (TGT_WREADY),
        .TGT_WID          (TGT_WID),
        .TGT_WDATA        (TGT_WDATA),
        .TGT_WSTRB        (TGT_WSTRB),
        .TGT_WLAST        (TGT_WLAST),
        .burst_done       (burst_done),
        .err_tgt_mismatch (err_tgt_mismatch),
        .beat_cnt         (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        m_burst  = 1'b0;
        accepted = 0;
    endtask

    // This task offers one beat and waits until the beat is accepted or the cycle budget runs out.
    // It returns 1 time unit after the accepting edge.
    task automatic apply_stimulus(input logic [10:0] id, input logic [1:0] tgt, input logic last);
        exp_t e;
        bit   done;
        done    = 1'b0;
        WVALID  = 1'b1;
        WID     = id;
        W_TgtID = tgt;
        WLAST   = last;
        WDATA   = {$urandom, $urandom, $urandom, $urandom};
        WSTRB   = SW'($urandom);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (WREADY) begin
                done   = 1'b1;
                e.wid  = id;
                e.data = WDATA;
                e.strb = WSTRB;
                e.last = last;
                if (m_burst) begin
                    e.tgt = m_tgt;
                    if (last) m_burst = 1'b0;
                end else begin
                    e.tgt = tgt;
                    if (!last) begin
                        m_burst = 1'b1;
                        m_tgt   = tgt;
                        m_wid   = id;
                    end
                end
                if (sb_en) sb.push_back(e);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        WVALID = 1'b0;
        if (!done) check_output("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check_output("drain_timeout", DW'(sb.size()), 0);
        @(posedge clk);
        #1;
        check_output("beat_cnt", DW'(beat_cnt), DW'(accepted[15:0]));
    endtask

    // A beat leaves at the next edge when its selected ready is high, and that is when it is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst && sb_en && ((TGT_WVALID & TGT_WREADY) != 4'b0)) begin
            if (sb.size() == 0) begin
                check_output("unexpected_beat", DW'(TGT_WVALID), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("tgt_wvalid", DW'(TGT_WVALID), DW'(4'b0001 << e.tgt));
                check_output("tgt_wid",    DW'(TGT_WID),    DW'(e.wid));
                check_output("tgt_wdata",  TGT_WDATA,       e.data);
                check_output("tgt_wstrb",  DW'(TGT_WSTRB),  DW'(e.strb));
                check_output("tgt_wlast",  DW'(TGT_WLAST),  DW'(e.last));
                check_output("burst_done", DW'(burst_done), DW'(e.last));
            end
        end
    end

    initial begin
        WVALID     = 1'b0;
        WID        = '0;
        WDATA      = '0;
        WSTRB      = '0;
        WLAST      = 1'b0;
        W_TgtID    = '0;
        TGT_WREADY = 4'hF;
        rst        = 1'b0;

        // Check the outputs while reset is held, then check the WREADY release.
        repeat (2) @(negedge clk);
        check_output("rst_wready",  DW'(WREADY), 0);
        check_output("rst_wvalid",  DW'(TGT_WVALID), 0);
        check_output("rst_done",    DW'(burst_done), 0);
        check_output("rst_err",     DW'(err_tgt_mismatch), 0);
        check_output("rst_cnt",     DW'(beat_cnt), 0);
        rst = 1'b1;
        #1;
        check_output("wready_before_edge", DW'(WREADY), 0);
        @(posedge clk);
        #1;
        check_output("wready_after_edge", DW'(WREADY), 1);

        // Send a 4-beat burst to target 2. The first beat must show up 1 cycle after it is accepted.
        apply_stimulus(11'h012, 2'd2, 1'b0);
        check_output("latency_wvalid", DW'(TGT_WVALID), DW'(4'b0100));
        apply_stimulus(11'h012, 2'd2, 1'b0);
        apply_stimulus(11'h012, 2'd2, 1'b0);
        apply_stimulus(11'h012, 2'd2, 1'b1);
        wait_drain();
        check_output("burst4_cnt", DW'(beat_cnt), 4);

        // With the targets stalled, the FIFO must fill after 4 beats and then refuse a 5th beat.
        TGT_WREADY = 4'h0;
        for (int i = 0; i < 4; i++) apply_stimulus(11'h005, 2'd0, i == 3);
        check_output("full_wready", DW'(WREADY), 0);
        WVALID = 1'b1;
        WID    = 11'h006;
        WLAST  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_wready", DW'(WREADY), 0);
            check_output("stall_wvalid", DW'(TGT_WVALID), DW'(4'b0001));
            check_output("stall_wdata",  TGT_WDATA, sb[0].data);
        end
        WVALID = 1'b0;
        @(posedge clk);
        #1;
        TGT_WREADY = 4'hF;
        wait_drain();

        // Target changes from 1 to 3 in the middle of a burst. The beats stay on target 1 and the error flag is set.
        apply_stimulus(11'h033, 2'd1, 1'b0);
        check_output("err_before", DW'(err_tgt_mismatch), 0);
        apply_stimulus(11'h033, 2'd3, 1'b0);
        check_output("err_after", DW'(err_tgt_mismatch), 1);
        apply_stimulus(11'h033, 2'd1, 1'b1);
        wait_drain();

        // Head-of-line blocking: while target 1 is stalled, the beats for targets 2 and 3 must wait.
        TGT_WREADY = 4'b1101;
        for (int t = 0; t < 4; t++) apply_stimulus(11'(16 + t), 2'(t), 1'b1);
        check_output("hol_head", DW'(TGT_WVALID), DW'(4'b0010));
        repeat (4) @(posedge clk);
        #1;
        check_output("hol_still", DW'(TGT_WVALID), DW'(4'b0010));
        TGT_WREADY = 4'hF;
        wait_drain();

        // Reset in the middle of a burst with 3 beats buffered.
        TGT_WREADY = 4'h0;
        for (int i = 0; i < 3; i++) apply_stimulus(11'h044, 2'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_output("mid_rst_wvalid", DW'(TGT_WVALID), 0);
        check_output("mid_rst_wready", DW'(WREADY), 0);
        check_output("mid_rst_cnt",    DW'(beat_cnt), 0);
        check_output("mid_rst_err",    DW'(err_tgt_mismatch), 0);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        TGT_WREADY = 4'hF;
        apply_stimulus(11'h055, 2'd3, 1'b1);
        wait_drain();

        // Send enough single-beat transfers that the 16-bit beat counter wraps.
        rst = 1'b0;
        #1;
        clear_model();
        sb_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 70000; i++) apply_stimulus(11'(i), 2'(i), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_output("wrap_cnt", DW'(beat_cnt), DW'(16'd4464));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
